// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial word feeder.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int   W_DEF        = 8;
    localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry hold register between the handshake and the shifter.
module ser_hold_buf #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         in_ready
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (wr) begin
            data_d = wdata;
            full_d = 1'b1;
        end else if (rd) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign rdata    = data_q;
    assign full     = full_q;
    assign in_ready = !full_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder with a one-word hold buffer and
// gapless streaming of back-to-back words.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int   W         = W_DEF,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
    input  logic         Clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_bit,
    output logic         ser_valid,
    output logic         word_start,
    output logic         busy
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ser_bit_q, ser_bit_d;
    logic          ser_valid_q, ser_valid_d;
    logic          word_start_q, word_start_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          load;
    logic          adv_en;
    logic [W-1:0]  load_word;
    logic          hold_wr;
    logic          hold_rd;
    logic [W-1:0]  hold_data;
    logic          hold_full;
    logic          hold_full_nx;

    // shift_q keeps the not-yet-sent bits with the next one at the head
    function automatic logic head(input logic [W-1:0] w);
        return MSB_FIRST ? w[W-1] : w[0];
    endfunction

    function automatic logic [W-1:0] adv(input logic [W-1:0] w);
        return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
    endfunction

    ser_hold_buf #(
        .W (W)
    ) u_hold (
        .Clk      (Clk),
        .reset_n  (reset_n),
        .wr       (hold_wr),
        .wdata    (in_data),
        .rd       (hold_rd),
        .rdata    (hold_data),
        .full     (hold_full),
        .in_ready (in_ready)
    );

    assign accept = reset_n & in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        adv_en    = 1'b0;
        load_word = in_data;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = accept;
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    adv_en  = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    hold_wr = accept;
                end else if (hold_full) begin
                    load      = 1'b1;
                    load_word = hold_data;
                    hold_rd   = 1'b1;
                    hold_wr   = accept;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        shift_d   = shift_q;
        ser_bit_d = IDLE_BIT;
        if (load) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            ser_bit_d = head(load_word);
            shift_d   = adv(load_word);
        end else if (adv_en) begin
            ser_bit_d = head(shift_q);
            shift_d   = adv(shift_q);
        end

        hold_full_nx = hold_wr | (hold_full & ~hold_rd);
        ser_valid_d  = (state_d == SHIFT);
        word_start_d = load;
        busy_d       = (state_d == SHIFT) | hold_full_nx;
    end

    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            ser_bit_q    <= IDLE_BIT;
            ser_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            ser_bit_q    <= ser_bit_d;
            ser_valid_q  <= ser_valid_d;
            word_start_q <= word_start_d;
            busy_q       <= busy_d;
        end
    end

    assign ser_bit    = ser_bit_q;
    assign ser_valid  = ser_valid_q;
    assign word_start = word_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances
// driven together and compared against a bit-queue reference.
module tb_serial_word_feeder;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic m_ready, m_bit, m_valid, m_start, m_busy;
    logic l_ready, l_bit, l_valid, l_start, l_busy;

    int checks = 0;
    int errs   = 0;

    // reference: every accepted word becomes W {start,bit} entries in
    // emission order; the head entry is what is on the wire
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    logic       acc_ev = 1'b0;

    always #5 clk = ~clk;

    serial_word_feeder #(
        .W (W), .MSB_FIRST (1'b1), .IDLE_BIT (IDLE)
    ) dut_m (
        .Clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (m_ready),
        .ser_bit    (m_bit),
        .ser_valid  (m_valid),
        .word_start (m_start),
        .busy       (m_busy)
    );

    serial_word_feeder #(
        .W (W), .MSB_FIRST (1'b0), .IDLE_BIT (IDLE)
    ) dut_l (
        .Clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (l_ready),
        .ser_bit    (l_bit),
        .ser_valid  (l_valid),
        .word_start (l_start),
        .busy       (l_busy)
    );

    always @(posedge clk) begin
        if (!reset_n) begin
            qm.delete();
            ql.delete();
            acc_ev = 1'b0;
        end else begin
            // a pending word beyond the one on the wire means no room
            acc_ev = in_valid && (qm.size() <= W);
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc_ev) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back({i == 0, in_data[W-1-i]});
                    ql.push_back({i == 0, in_data[i]});
                end
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic v;
        v = qm.size() > 0;
        chk("m_valid", m_valid, v);
        chk("m_bit",   m_bit,   v ? qm[0][0] : IDLE);
        chk("m_start", m_start, v && qm[0][1]);
        chk("m_busy",  m_busy,  v);
        chk("m_ready", m_ready, qm.size() <= W);
        v = ql.size() > 0;
        chk("l_valid", l_valid, v);
        chk("l_bit",   l_bit,   v ? ql[0][0] : IDLE);
        chk("l_start", l_start, v && ql[0][1]);
        chk("l_busy",  l_busy,  v);
        chk("l_ready", l_ready, ql.size() <= W);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [W-1:0] w);
        logic got;
        got      = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            step();
            got = acc_ev;
        end
        chk("send_accepted", got, 1'b1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] cap;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk);
        step();
        chk("reset_no_accept", m_valid, 1'b0);
        chk("reset_ready", m_ready, 1'b1);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();

        // single word, captured bit by bit off the wire
        send(8'h99);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            cap = {cap[6:0], m_bit};
        end
        chk8("msb_99", cap, 8'h99);
        repeat (3) step();
        chk("idle_after_99", m_bit, IDLE);

        // back-to-back
        send(8'hA5);
        send(8'h3C);
        chk("ready_low_hold", m_ready, 1'b0);
        repeat (18) step();

        // last-bit bypass
        send(8'hC3);
        repeat (7) step();
        send(8'hF0);
        chk("bypass_start", m_start, 1'b1);
        repeat (10) step();

        // backpressure: hold full while 8'h55 waits
        send(8'h12);
        send(8'h34);
        send(8'h55);
        repeat (20) step();

        // reset during bit 3
        send(8'hFF);
        repeat (3) step();
        reset_n = 1'b0;
        step();
        chk("rst_mid_busy", m_busy, 1'b0);
        chk("rst_mid_bit", m_bit, IDLE);
        reset_n = 1'b1;
        step();
        send(8'h81);
        chk("restart_start", m_start, 1'b1);
        repeat (10) step();

        // LSB-first with 8'h01
        send(8'h01);
        cap = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            cap = {l_bit, cap[7:1]};
        end
        chk8("lsb_01", cap, 8'h01);
        repeat (3) step();

        // random traffic, data held stable while stalled
        for (int c = 0; c < 400; c++) begin
            if (!(in_valid && !acc_ev)) begin
                in_valid = 1'($urandom_range(0, 2) != 0);
                in_data  = W'($urandom);
            end
            reset_n = ($urandom_range(0, 79) != 0);
            step();
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
